// File: rtl/jt51_wrq_if.sv
// jt51_wrq_if -- CPU-side bus of a jt51 core as seen by the write queue.
//
// Signals:
//   jt_cs_n  chip select, active low   (driven by the queue)
//   jt_wr_n  write strobe, active low  (driven by the queue)
//   jt_a0    0 = register address, 1 = register data
//   jt_din   byte written into the jt51
//   jt_dout  jt51 status byte, bit 7 = busy (driven by the jt51)
//
// Modports:
//   master  the write queue (drives the strobe, reads status)
//   slave   the jt51 core (or a bench model of it)
interface jt51_wrq_if;
  logic       jt_cs_n;
  logic       jt_wr_n;
  logic       jt_a0;
  logic [7:0] jt_din;
  logic [7:0] jt_dout;

  modport master (
    output jt_cs_n,
    output jt_wr_n,
    output jt_a0,
    output jt_din,
    input  jt_dout
  );

  modport slave (
    input  jt_cs_n,
    input  jt_wr_n,
    input  jt_a0,
    input  jt_din,
    output jt_dout
  );
endinterface

// File: rtl/jt51_wrq.sv
// jt51_wrq -- host write queue in front of a jt51 FM core.
//
// Host writes ({a0, byte}) are buffered in a DEPTH-entry FIFO and replayed
// to the jt51 one at a time: a 2-cycle cs_n/wr_n strobe, HOLD idle cycles,
// and, after a data write (a0=1), a wait until the jt51 busy flag clears.
// The busy wait is guarded by a 1023-cycle watchdog.
//
// Parameters:
//   DEPTH  FIFO entries, power of two, 4..256
//   HOLD   idle cycles after each strobe, 1..15
//
// Ports:
//   clk       main clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr        host write request (one entry per cycle high)
//   wr_a0     host a0
//   wr_din    host byte
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   level     current entry count
//   drop_cnt  number of host writes rejected because the FIFO was full
//   jt        jt51 bus (jt51_wrq_if master modport)
//
// Optional feature (macro JT51_WRQ_STATS_EN):
//   defined    drop_cnt counts dropped writes, saturating at 255
//   undefined  drop_cnt is tied to 0
module jt51_wrq #(
  parameter int DEPTH = 16,
  parameter int HOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic                     wr_a0,
  input  logic [7:0]               wr_din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt,
  jt51_wrq_if.master               jt
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [3:0]     HOLD_LAST = 4'(HOLD - 1);
  localparam logic [9:0]     WD_LAST   = 10'd1022;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_HOLD,
    ST_WAITB
  } state_t;

  state_t         state;
  logic [8:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           pop;
  logic           strobe_n;
  logic           out_a0;
  logic [7:0]     out_din;
  logic [3:0]     sub_cnt;
  logic [9:0]     wd_cnt;
  logic           busy;
  logic [6:0]     unused_status;

  assign busy          = jt.jt_dout[7];
  assign unused_status = jt.jt_dout[6:0];

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign push  = wr & ~full;
  assign pop   = (state == ST_IDLE) & ~empty;

  // One register drives both strobes so cs_n and wr_n can never differ.
  assign jt.jt_cs_n = strobe_n;
  assign jt.jt_wr_n = strobe_n;
  assign jt.jt_a0   = out_a0;
  assign jt.jt_din  = out_din;

  // Storage has no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_a0, wr_din};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The entry is latched on the IDLE pop edge; the strobe drops one edge
  // later so a0/din are already stable when cs_n falls. sub_cnt counts the
  // STROBE (0..2) and HOLD (0..HOLD-1) phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      strobe_n <= 1'b1;
      out_a0   <= 1'b0;
      out_din  <= 8'h00;
      sub_cnt  <= 4'd0;
      wd_cnt   <= 10'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          strobe_n <= 1'b1;
          if (!empty) begin
            {out_a0, out_din} <= mem[rd_ptr];
            sub_cnt           <= 4'd0;
            state             <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (sub_cnt == 4'd2) begin
            strobe_n <= 1'b1;
            sub_cnt  <= 4'd0;
            state    <= ST_HOLD;
          end else begin
            strobe_n <= 1'b0;
            sub_cnt  <= sub_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          strobe_n <= 1'b1;
          if (sub_cnt == HOLD_LAST) begin
            sub_cnt <= 4'd0;
            wd_cnt  <= 10'd0;
            state   <= out_a0 ? ST_WAITB : ST_IDLE;
          end else begin
            sub_cnt <= sub_cnt + 4'd1;
          end
        end
        ST_WAITB: begin
          strobe_n <= 1'b1;
          // The 1023rd consecutive busy cycle gives up on the jt51.
          if (!busy || wd_cnt == WD_LAST) begin
            wd_cnt <= 10'd0;
            state  <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 10'd1;
          end
        end
        default: begin
          strobe_n <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JT51_WRQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if (wr && full && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_jt51_wrq.sv
// tb_jt51_wrq -- directed self-checking bench for jt51_wrq (DEPTH=16, HOLD=4).
//
// Inputs change on the falling edge and outputs are checked there too.
// A monitor logs every cs_n falling edge ({a0,din} and cycle number) and
// the length of each strobe, so ordering and spacing can be checked.
// Expected drop_cnt values follow JT51_WRQ_STATS_EN.
module tb_jt51_wrq;

`ifdef JT51_WRQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       wr_a0;
  logic [7:0] wr_din;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic [7:0] drop_cnt;

  jt51_wrq_if bus ();

  jt51_wrq #(.DEPTH(16), .HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .wr_a0    (wr_a0),
    .wr_din   (wr_din),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .drop_cnt (drop_cnt),
    .jt       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cs_wr_diff = 0;
  int         low_cnt = 0;
  logic       prev_cs = 1'b1;
  logic [8:0] seen_q [$];
  int         start_q [$];
  int         len_q [$];

  // Strobe monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.jt_cs_n !== bus.jt_wr_n) cs_wr_diff++;
    if (bus.jt_cs_n === 1'b0) begin
      if (prev_cs) begin
        seen_q.push_back({bus.jt_a0, bus.jt_din});
        start_q.push_back(cyc);
        low_cnt = 0;
      end
      low_cnt++;
    end else if (!prev_cs) begin
      len_q.push_back(low_cnt);
    end
    prev_cs = bus.jt_cs_n;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic a0, input logic [7:0] d);
    @(negedge clk);
    wr     = w;
    wr_a0  = a0;
    wr_din = d;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clearLog();
    seen_q.delete();
    start_q.delete();
    len_q.delete();
  endtask

  task automatic waitStrobes(input int n, input int budget, input string tag);
    int k = 0;
    while (seen_q.size() < n && k < budget) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      k++;
    end
    checkOutput(tag, 32'(seen_q.size() >= n), 1);
  endtask

  function automatic logic [31:0] seenAt(input int i);
    return (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] startGap(input int i);
    return (i + 1 < start_q.size()) ? 32'(start_q[i+1] - start_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lenAt(input int i);
    return (i < len_q.size()) ? 32'(len_q[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst_n       = 1'b0;
    wr          = 1'b0;
    wr_a0       = 1'b0;
    wr_din      = 8'h00;
    bus.jt_dout = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n",  32'(bus.jt_cs_n), 1);
    checkOutput("rst_wr_n",  32'(bus.jt_wr_n), 1);
    checkOutput("rst_a0",    32'(bus.jt_a0), 0);
    checkOutput("rst_din",   32'(bus.jt_din), 0);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full",  32'(full), 0);
    checkOutput("rst_drop",  32'(drop_cnt), 0);

    // Push on the first edge after release; strobe starts two edges later
    applyStimulus(1'b1, 1'b0, 8'h14);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("lat_e0_level", 32'(level), 1);
    checkOutput("lat_e0_empty", 32'(empty), 0);
    checkOutput("lat_e0_cs_n",  32'(bus.jt_cs_n), 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("lat_e1_level", 32'(level), 0);
    checkOutput("lat_e1_cs_n",  32'(bus.jt_cs_n), 1);
    checkOutput("lat_e1_din",   32'(bus.jt_din), 'h14);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("lat_e2_cs_n",  32'(bus.jt_cs_n), 0);
    checkOutput("lat_e2_wr_n",  32'(bus.jt_wr_n), 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("lat_e3_cs_n",  32'(bus.jt_cs_n), 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("lat_e4_cs_n",  32'(bus.jt_cs_n), 1);
    idleCycles(10);
    checkOutput("lat_entry", seenAt(0), 'h014);
    checkOutput("lat_len",   lenAt(0), 2);

    // Address then data with busy high: data strobe 8 cycles after the
    // address strobe, third entry held until busy falls
    clearLog();
    bus.jt_dout = 8'h80;
    applyStimulus(1'b1, 1'b0, 8'h14);
    applyStimulus(1'b1, 1'b1, 8'h30);
    applyStimulus(1'b1, 1'b0, 8'h55);
    idleCycles(30);
    checkOutput("busy_count",  32'(seen_q.size()), 2);
    checkOutput("busy_first",  seenAt(0), 'h014);
    checkOutput("busy_second", seenAt(1), 'h130);
    checkOutput("busy_gap",    startGap(0), 8);
    checkOutput("busy_level",  32'(level), 1);
    bus.jt_dout = 8'h00;
    waitStrobes(3, 30, "busy_release");
    checkOutput("busy_third",  seenAt(2), 'h055);
    checkOutput("busy_len0",   lenAt(0), 2);
    checkOutput("busy_len1",   lenAt(1), 2);
    idleCycles(15);

    // Fill while the FSM is parked in the busy wait, then overflow
    clearLog();
    bus.jt_dout = 8'h80;
    applyStimulus(1'b1, 1'b1, 8'hA5);
    idleCycles(15);
    checkOutput("fill_start_level", 32'(level), 0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
    applyStimulus(1'b1, 1'b0, 8'hEE);
    checkOutput("fill_full",  32'(full), 1);
    checkOutput("fill_level", 32'(level), 16);
    checkOutput("fill_empty", 32'(empty), 0);
    applyStimulus(1'b1, 1'b0, 8'hEF);
    checkOutput("drop1_level", 32'(level), 16);
    checkOutput("drop1_cnt",   32'(drop_cnt), STATS ? 1 : 0);
    repeat (299) applyStimulus(1'b1, 1'b0, 8'hEF);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("drop301_cnt",   32'(drop_cnt), STATS ? 255 : 0);
    checkOutput("drop301_level", 32'(level), 16);
    bus.jt_dout = 8'h00;
    waitStrobes(17, 400, "drain_done");
    for (int i = 0; i < 16; i++) checkOutput($sformatf("drain_%0d", i), seenAt(i + 1), 32'(9'h040 + i));
    checkOutput("drain_empty", 32'(empty), 1);
    checkOutput("drain_full",  32'(full), 0);
    checkOutput("drain_drop",  32'(drop_cnt), STATS ? 255 : 0);
    idleCycles(10);

    // Busy stuck high: watchdog releases after 1023 busy cycles
    clearLog();
    bus.jt_dout = 8'h80;
    applyStimulus(1'b1, 1'b1, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'hBB);
    idleCycles(1000);
    checkOutput("wd_holding", 32'(seen_q.size()), 1);
    waitStrobes(2, 100, "wd_release");
    checkOutput("wd_gap",    startGap(0), 1031);
    checkOutput("wd_first",  seenAt(0), 'h1AA);
    checkOutput("wd_second", seenAt(1), 'h0BB);
    bus.jt_dout = 8'h00;
    idleCycles(10);

    // Reset during the first strobe cycle
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h78);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("abort_pre_cs_n", 32'(bus.jt_cs_n), 0);
    checkOutput("abort_pre_din",  32'(bus.jt_din), 'h77);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_cs_n",  32'(bus.jt_cs_n), 1);
    checkOutput("abort_wr_n",  32'(bus.jt_wr_n), 1);
    checkOutput("abort_level", 32'(level), 0);
    checkOutput("abort_empty", 32'(empty), 1);
    checkOutput("abort_din",   32'(bus.jt_din), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(20);
    checkOutput("abort_quiet", 32'(seen_q.size()), 1);
    applyStimulus(1'b1, 1'b0, 8'h79);
    waitStrobes(2, 20, "abort_new_push");
    checkOutput("abort_new_entry", seenAt(1), 'h079);
    idleCycles(10);

    checkOutput("cs_wr_equal", 32'(cs_wr_diff), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
